// File: rtl/conv_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_pkg
// Description : Shared types and constants for the convolution sequencing
//               controller and its window counter.
// Contents    : state_t  - controller state encoding
//               PIX_CNT_W, COORD_W, MAX_MEM_LAT, CMP_W - widths and limits
// Revision    : 1.0 - initial release
// ============================================================================
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FETCH = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4,
    SLIDE = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int PIX_CNT_W   = 10;
  localparam int COORD_W     = 10;
  localparam int MAX_MEM_LAT = 3;
  // One bit wider than the coordinates so W-m / H-m can never wrap.
  localparam int CMP_W       = 11;

  // Zero-extend a kernel side to the comparison width.
  function automatic logic [CMP_W-1:0] ext_m(input logic [3:0] m_in);
    return {{(CMP_W-4){1'b0}}, m_in};
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_seq_ctrl_win_counter.sv
`default_nettype none
// ============================================================================
// Module      : conv_win_counter
// Description : Row-major window origin counter for the convolution
//               sequencer. Clears on i_clr, advances one column per i_adv
//               and wraps to the next row at the right edge.
// Ports       : clk, rstn         - clock, asynchronous active-low reset
//               i_clr             - return to window (0,0)
//               i_adv             - step to the next window
//               i_m               - latched kernel side
//               o_win_col/o_win_row - current window origin
//               o_last            - current window is the final one
// Revision    : 1.0 - initial release
// ============================================================================
module conv_win_counter
  import conv_pkg::*;
#(
  parameter int W = 220,
  parameter int H = 220
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_clr,
  input  logic               i_adv,
  input  logic [3:0]         i_m,
  output logic [COORD_W-1:0] o_win_col,
  output logic [COORD_W-1:0] o_win_row,
  output logic               o_last
);

  localparam logic [CMP_W-1:0] c_w = CMP_W'(W);
  localparam logic [CMP_W-1:0] c_h = CMP_W'(H);

  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;
  logic [CMP_W-1:0]   w_col_max;
  logic [CMP_W-1:0]   w_row_max;
  logic [CMP_W-1:0]   w_col_ext;
  logic [CMP_W-1:0]   w_row_ext;

  assign w_col_max = c_w - ext_m(i_m);
  assign w_row_max = c_h - ext_m(i_m);
  assign w_col_ext = {1'b0, r_col};
  assign w_row_ext = {1'b0, r_row};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_adv) begin
      if (w_col_ext < w_col_max) begin
        r_col <= r_col + 1'b1;
      end else begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end
    end
  end

  assign o_win_col = r_col;
  assign o_win_row = r_row;
  assign o_last    = (w_col_ext == w_col_max) && (w_row_ext == w_row_max);

endmodule
`default_nettype wire

// File: rtl/conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_seq_ctrl
// Description : Sequencing controller for the convolution address generator
//               and MAC datapath. Per start, walks an m x m kernel over a
//               W x H image (row-major, stride 1), issuing fetch, MAC
//               enable/clear, a result handshake and a slide pulse per window.
// Ports       : clk, rstn          - clock, asynchronous active-low reset
//               start, m           - start request and kernel side
//               res_ready          - result sink ready
//               fetch, slide       - fetch enable, window-advance pulse
//               pixel_count        - kernel element index
//               mac_clr, mac_en    - accumulator clear / enable
//               res_valid          - result valid
//               busy, done, err    - status
//               win_col, win_row   - window origin
//               stall_cycles       - only with CONV_STALL_CNT_EN
// Options     : CONV_STALL_CNT_EN  - adds the 32-bit WRITE stall counter
// Revision    : 1.0 - initial release
// ============================================================================
module conv_seq_ctrl
  import conv_pkg::*;
#(
  parameter int W       = 220,
  parameter int H       = 220,
  parameter int MAX_M   = 7,
  parameter int MEM_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [3:0]           m,
  input  logic                 res_ready,
  output logic                 fetch,
  output logic                 slide,
  output logic [PIX_CNT_W-1:0] pixel_count,
  output logic                 mac_clr,
  output logic                 mac_en,
  output logic                 res_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [COORD_W-1:0]   win_col,
  output logic [COORD_W-1:0]   win_row
`ifdef CONV_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam int               c_drain_w    = $clog2(MAX_MEM_LAT + 1);
  localparam logic [c_drain_w-1:0] c_drain_last = c_drain_w'(MEM_LAT - 1);
  localparam logic [CMP_W-1:0] c_max_m = CMP_W'(MAX_M);
  localparam logic [CMP_W-1:0] c_w     = CMP_W'(W);
  localparam logic [CMP_W-1:0] c_h     = CMP_W'(H);

  state_t                 r_state;
  logic [3:0]             r_m;
  logic [6:0]             r_msq;
  logic [PIX_CNT_W-1:0]   r_pix;
  logic [c_drain_w-1:0]   r_drain;
  logic                   r_fetch;
  logic                   r_slide;
  logic                   r_res_valid;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;

  logic                   w_m_ok;
  logic [6:0]             w_msq;
  logic [PIX_CNT_W-1:0]   w_pix_last;
  logic                   w_last;
  logic                   w_first_beat;
  logic                   w_mac_en;
  logic                   w_mac_clr;

  assign w_m_ok = (m != 4'd0) && (ext_m(m) <= c_max_m) &&
                  (ext_m(m) <= c_w) && (ext_m(m) <= c_h);

  // m <= 7 is guaranteed by the start check, so 7 bits hold m*m.
  assign w_msq      = {3'd0, r_m} * {3'd0, r_m};
  assign w_pix_last = {3'd0, r_msq} - 10'd1;

  // ---------------------------------------------------------------------------
  // Controller FSM; every output is a flop written alongside the transition.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_m         <= '0;
      r_msq       <= '0;
      r_pix       <= '0;
      r_drain     <= '0;
      r_fetch     <= 1'b0;
      r_slide     <= 1'b0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_slide <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_m_ok) begin
              r_m     <= m;
              r_busy  <= 1'b1;
              r_state <= LOAD;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          r_msq   <= w_msq;
          r_pix   <= '0;
          r_fetch <= 1'b1;
          r_state <= FETCH;
        end
        FETCH: begin
          if (r_pix == w_pix_last) begin
            r_fetch <= 1'b0;
            r_drain <= '0;
            r_state <= DRAIN;
          end else begin
            r_pix <= r_pix + 1'b1;
          end
        end
        DRAIN: begin
          // Leave once the final fetch has emerged as a mac_en beat.
          if (r_drain == c_drain_last) begin
            r_res_valid <= 1'b1;
            r_state     <= WRITE;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        WRITE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_slide <= 1'b1;
              r_pix   <= '0;
              r_state <= SLIDE;
            end
          end
        end
        SLIDE: begin
          r_fetch <= 1'b1;
          r_state <= FETCH;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Memory-latency alignment of the MAC controls.
  // ---------------------------------------------------------------------------
  assign w_first_beat = r_fetch && (r_pix == '0);

  generate
    if (MEM_LAT <= 1) begin : g_lat_one
      logic r_en_q;
      logic r_clr_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_en_q  <= 1'b0;
          r_clr_q <= 1'b0;
        end else begin
          r_en_q  <= r_fetch;
          r_clr_q <= w_first_beat;
        end
      end
      assign w_mac_en  = r_en_q;
      assign w_mac_clr = r_clr_q;
    end else begin : g_lat_multi
      logic [MEM_LAT-1:0] r_en_q;
      logic [MEM_LAT-1:0] r_clr_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_en_q  <= '0;
          r_clr_q <= '0;
        end else begin
          r_en_q  <= {r_en_q[MEM_LAT-2:0], r_fetch};
          r_clr_q <= {r_clr_q[MEM_LAT-2:0], w_first_beat};
        end
      end
      assign w_mac_en  = r_en_q[MEM_LAT-1];
      assign w_mac_clr = r_clr_q[MEM_LAT-1];
    end
  endgenerate

  conv_win_counter #(
    .W (W),
    .H (H)
  ) u_win_counter (
    .clk       (clk),
    .rstn      (rstn),
    .i_clr     (r_state == LOAD),
    .i_adv     (r_state == SLIDE),
    .i_m       (r_m),
    .o_win_col (win_col),
    .o_win_row (win_row),
    .o_last    (w_last)
  );

`ifdef CONV_STALL_CNT_EN
  logic [31:0] r_stall;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall <= '0;
    end else if ((r_state == IDLE) && start && w_m_ok) begin
      r_stall <= '0;
    end else if ((r_state == WRITE) && !res_ready && (r_stall != 32'hFFFF_FFFF)) begin
      r_stall <= r_stall + 32'd1;
    end
  end
  assign stall_cycles = r_stall;
`endif

  assign fetch       = r_fetch;
  assign slide       = r_slide;
  assign pixel_count = r_pix;
  assign mac_clr     = w_mac_clr;
  assign mac_en      = w_mac_en;
  assign res_valid   = r_res_valid;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_conv_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_seq_ctrl
// Description : Self-checking bench for conv_seq_ctrl. Instance a: 8x8 image,
//               MEM_LAT=1. Instance b: 4x4 image, MEM_LAT=3. Window origins
//               expected at each result handshake are queued at start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_seq_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic       a_start = 1'b0, a_res_ready = 1'b1;
  logic [3:0] a_m = 4'd0;
  logic       a_fetch, a_slide, a_mac_clr, a_mac_en, a_res_valid, a_busy, a_done, a_err;
  logic [9:0] a_pix, a_col, a_row;

  logic       b_start = 1'b0, b_res_ready = 1'b1;
  logic [3:0] b_m = 4'd0;
  logic       b_fetch, b_slide, b_mac_clr, b_mac_en, b_res_valid, b_busy, b_done, b_err;
  logic [9:0] b_pix, b_col, b_row;
`ifdef CONV_STALL_CNT_EN
  logic [31:0] a_stall, b_stall;
`endif

  int total = 0;
  int bad   = 0;
  int sb_col[$];
  int sb_row[$];

  conv_seq_ctrl #(.W(8), .H(8), .MAX_M(7), .MEM_LAT(1)) u_dut_a (
    .clk(clk), .rstn(rstn), .start(a_start), .m(a_m), .res_ready(a_res_ready),
    .fetch(a_fetch), .slide(a_slide), .pixel_count(a_pix), .mac_clr(a_mac_clr),
    .mac_en(a_mac_en), .res_valid(a_res_valid), .busy(a_busy), .done(a_done),
    .err(a_err), .win_col(a_col), .win_row(a_row)
`ifdef CONV_STALL_CNT_EN
    , .stall_cycles(a_stall)
`endif
  );

  conv_seq_ctrl #(.W(4), .H(4), .MAX_M(7), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(b_start), .m(b_m), .res_ready(b_res_ready),
    .fetch(b_fetch), .slide(b_slide), .pixel_count(b_pix), .mac_clr(b_mac_clr),
    .mac_en(b_mac_en), .res_valid(b_res_valid), .busy(b_busy), .done(b_done),
    .err(b_err), .win_col(b_col), .win_row(b_row)
`ifdef CONV_STALL_CNT_EN
    , .stall_cycles(b_stall)
`endif
  );

  // Runs one sequence on instance a and returns event counts. Window origins
  // are compared against the queue at every handshake; per-cycle protocol
  // violations (latency alignment, pixel order, per-window length) are
  // accumulated in c_bad.
  task automatic run_a(input int mm, input int hold0, input int rs_m, input int abort_win,
                       output int c_fetch, output int c_en, output int c_res,
                       output int c_slide, output int c_done, output int c_hold,
                       output int c_bad);
    int  cyc = 0;
    bit  fin = 0;
    int  pix_exp = 0;
    int  win_fetch = 0;
    int  held = 0;
    bit  inj = 0;
    logic prev_fetch = 1'b0;
    logic prev_first = 1'b0;
    int  col, row;
    c_fetch = 0; c_en = 0; c_res = 0; c_slide = 0; c_done = 0; c_hold = 0; c_bad = 0;
    sb_col.delete(); sb_row.delete();
    @(posedge clk); #1;
    a_m = 4'(mm); a_start = 1'b1;
    for (int r = 0; r <= 8 - mm; r++)
      for (int c = 0; c <= 8 - mm; c++) begin
        sb_col.push_back(c); sb_row.push_back(r);
      end
    @(posedge clk); #1;
    a_start = 1'b0;
    while (!fin && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (inj) begin a_start = 1'b0; inj = 0; end
      if (a_mac_en !== prev_fetch || a_mac_clr !== prev_first) c_bad++;
      if (a_fetch) begin
        if (a_pix !== 10'(pix_exp)) c_bad++;
        pix_exp++; win_fetch++; c_fetch++;
        if (rs_m != 0 && c_fetch == 3) begin a_start = 1'b1; a_m = 4'(rs_m); inj = 1; end
      end
      if (a_mac_en) c_en++;
      if (a_slide) begin c_slide++; pix_exp = 0; win_fetch = 0; end
      if (a_done) begin c_done++; fin = 1; end
      if (abort_win >= 0 && c_res == abort_win && prev_fetch && !a_fetch && a_busy) begin
        rstn = 1'b0;
        fin = 1;
      end else if (a_res_valid) begin
        if (a_slide || a_fetch) c_bad++;
        if (held < hold0) begin
          a_res_ready = 1'b0; held++; c_hold++;
        end else begin
          a_res_ready = 1'b1;
          if (win_fetch != mm * mm) c_bad++;
          if (sb_col.size() == 0) begin
            total++; bad++;
            $display("FAIL sb_underflow got=extra_result required=none");
          end else begin
            col = sb_col.pop_front(); row = sb_row.pop_front();
            total++;
            if (a_col !== 10'(col) || a_row !== 10'(row)) begin
              bad++;
              $display("FAIL sb_window got=(%0d,%0d) required=(%0d,%0d)", a_col, a_row, col, row);
            end
          end
          c_res++;
        end
      end else begin
        a_res_ready = 1'b1;
      end
      prev_fetch = a_fetch;
      prev_first = a_fetch && (a_pix == 10'd0);
    end
    a_res_ready = 1'b1;
    if (!fin) begin
      total++; bad++;
      $display("FAIL run_timeout got=no_done required=done");
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({a_fetch, a_slide, a_mac_clr, a_mac_en, a_res_valid, a_busy, a_done, a_err} !== 8'd0) begin
      bad++; $display("FAIL reset_flags_a got=%b required=0", {a_fetch, a_slide, a_mac_clr, a_mac_en, a_res_valid, a_busy, a_done, a_err});
    end
    total++;
    if (a_pix !== 10'd0 || a_col !== 10'd0 || a_row !== 10'd0) begin
      bad++; $display("FAIL reset_counts_a got=%0d/%0d/%0d required=0", a_pix, a_col, a_row);
    end
    total++;
    if ({b_fetch, b_mac_en, b_res_valid, b_busy, b_done, b_err} !== 6'd0) begin
      bad++; $display("FAIL reset_flags_b got=%b required=0", {b_fetch, b_mac_en, b_res_valid, b_busy, b_done, b_err});
    end
    rstn = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_bad_m();
    int vals[2] = '{0, 8};
    foreach (vals[i]) begin
      @(posedge clk); #1;
      a_m = 4'(vals[i]); a_start = 1'b1;
      @(posedge clk); #1;
      a_start = 1'b0;
      @(negedge clk);
      total++;
      if (a_err !== 1'b1 || a_busy !== 1'b0 || a_fetch !== 1'b0) begin
        bad++; $display("FAIL bad_m_%0d got=err%b busy%b fetch%b required=err1 busy0 fetch0", vals[i], a_err, a_busy, a_fetch);
      end
      @(negedge clk);
      total++;
      if (a_err !== 1'b0 || a_busy !== 1'b0) begin
        bad++; $display("FAIL bad_m_pulse_%0d got=err%b busy%b required=err0 busy0", vals[i], a_err, a_busy);
      end
    end
  endtask

  task automatic test_full(input int mm, input int rs_m);
    int f, e, r, s, d, h, b;
    int nwin;
    nwin = (9 - mm) * (9 - mm);
    run_a(mm, 0, rs_m, -1, f, e, r, s, d, h, b);
    total++;
    if (f != nwin * mm * mm || e != nwin * mm * mm) begin
      bad++; $display("FAIL full_m%0d_beats got=fetch%0d en%0d required=%0d", mm, f, e, nwin * mm * mm);
    end
    total++;
    if (r != nwin || s != nwin - 1 || d != 1) begin
      bad++; $display("FAIL full_m%0d_events got=res%0d slide%0d done%0d required=%0d/%0d/1", mm, r, s, d, nwin, nwin - 1);
    end
    total++;
    if (b != 0) begin
      bad++; $display("FAIL full_m%0d_protocol got=%0d violations required=0", mm, b);
    end
    total++;
    if (a_col !== 10'(8 - mm) || a_row !== 10'(8 - mm)) begin
      bad++; $display("FAIL full_m%0d_final got=(%0d,%0d) required=(%0d,%0d)", mm, a_col, a_row, 8 - mm, 8 - mm);
    end
    @(negedge clk);
    total++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      bad++; $display("FAIL full_m%0d_idle got=busy%b done%b required=0", mm, a_busy, a_done);
    end
  endtask

  task automatic test_stall();
    int f, e, r, s, d, h, b;
    run_a(3, 20, 0, -1, f, e, r, s, d, h, b);
    total++;
    if (h != 20 || r != 36 || s != 35 || b != 0) begin
      bad++; $display("FAIL stall got=hold%0d res%0d slide%0d viol%0d required=20/36/35/0", h, r, s, b);
    end
`ifdef CONV_STALL_CNT_EN
    total++;
    if (a_stall !== 32'd20) begin
      bad++; $display("FAIL stall_count got=%0d required=20", a_stall);
    end
`endif
  endtask

  task automatic test_abort();
    int f, e, r, s, d, h, b;
    run_a(3, 0, 0, 4, f, e, r, s, d, h, b);
    #1;
    total++;
    if ({a_fetch, a_slide, a_mac_clr, a_mac_en, a_res_valid, a_busy, a_done, a_err} !== 8'd0 ||
        a_pix !== 10'd0 || a_col !== 10'd0 || a_row !== 10'd0) begin
      bad++; $display("FAIL abort_clear got=busy%b fetch%b pix%0d col%0d required=all0", a_busy, a_fetch, a_pix, a_col);
    end
    total++;
    if (r != 4 || d != 0) begin
      bad++; $display("FAIL abort_point got=res%0d done%0d required=4/0", r, d);
    end
    @(negedge clk);
    rstn = 1'b1;
    test_full(3, 0);
  endtask

  task automatic test_single_window();
    logic [2:0] hist = 3'b000;
    int f = 0, e = 0, r = 0, s = 0, d = 0, viol = 0, first_f = -1, first_e = -1;
    int cyc = 0;
    @(posedge clk); #1;
    b_m = 4'd4; b_start = 1'b1;
    @(posedge clk); #1;
    b_start = 1'b0;
    while (d == 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (b_mac_en !== hist[2]) viol++;
      if (b_fetch) begin f++; if (first_f < 0) first_f = cyc; end
      if (b_mac_en) begin e++; if (first_e < 0) first_e = cyc; end
      if (b_res_valid) r++;
      if (b_slide) s++;
      if (b_done) d++;
      hist = {hist[1:0], b_fetch};
    end
    total++;
    if (f != 16 || e != 16) begin
      bad++; $display("FAIL single_beats got=fetch%0d en%0d required=16/16", f, e);
    end
    total++;
    if (first_e - first_f != 3 || viol != 0) begin
      bad++; $display("FAIL single_latency got=lag%0d viol%0d required=3/0", first_e - first_f, viol);
    end
    total++;
    if (r != 1 || s != 0 || d != 1) begin
      bad++; $display("FAIL single_events got=res%0d slide%0d done%0d required=1/0/1", r, s, d);
    end
  endtask

  initial begin
    test_reset();
    test_bad_m();
    test_full(3, 0);
    test_full(1, 0);
    test_full(7, 0);
    test_stall();
    test_full(3, 5);
    test_abort();
    test_single_window();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
